// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: widths, FSM state and request latch types for the data-memory responder.
package dmem_responder_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} dmem_state_t;
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [DATA_WIDTH-1:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: mem1 request, mem2 completion and SRAM-style bus signals of the responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;
  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  data_ok;
  logic [DATA_WIDTH-1:0] cache_data_o;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input  flush, req_valid, req_we, req_addr, req_wstrb, req_wdata, mem_ack, mem_rvalid, mem_rdata,
    output req_ready, data_ok, cache_data_o, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
  modport master (
    output flush, req_valid, req_we, req_addr, req_wstrb, req_wdata, mem_ack, mem_rvalid, mem_rdata,
    input  req_ready, data_ok, cache_data_o, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: runs one mem1 load/store on the SRAM bus and returns a one-cycle data_ok to mem2.
module dmem_responder
  import dmem_responder_pkg::*;
(
  input logic          clk,
  input logic          rst,
  dmem_responder_if.slave bus
);
  dmem_state_t           state_q, state_d;
  dmem_req_t             req_q, req_d;
  logic                  cancel_q, cancel_d;
  logic                  data_ok_q, data_ok_d;
  logic [DATA_WIDTH-1:0] cache_q, cache_d;
  logic                  is_load;
  assign is_load = !req_q.we;
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cancel_d  = cancel_q;
    data_ok_d = 1'b0;
    cache_d   = '0;
    case (state_q)
      IDLE: if (bus.req_valid && !bus.flush) begin
        req_d    = '{we: bus.req_we, addr: bus.req_addr, wstrb: bus.req_wstrb, wdata: bus.req_wdata};
        cancel_d = 1'b0;
        state_d  = REQ;
      end
      REQ: begin
        cancel_d = cancel_q | (bus.flush & is_load);
        state_d  = bus.mem_ack ? WAIT : REQ;
      end
      WAIT: if (bus.mem_rvalid) begin
        // A load killed by an earlier or same-cycle flush completes on the bus silently.
        data_ok_d = !(cancel_q || (bus.flush && is_load));
        cache_d   = (data_ok_d && is_load) ? bus.mem_rdata : '0;
        cancel_d  = 1'b0;
        state_d   = IDLE;
      end else if (bus.flush && is_load) begin
        cancel_d = 1'b1;
        state_d  = DRAIN;
      end
      DRAIN: if (bus.mem_rvalid) begin
        cancel_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cancel_q  <= 1'b0;
      data_ok_q <= 1'b0;
      cache_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cancel_q  <= cancel_d;
      data_ok_q <= data_ok_d;
      cache_q   <= cache_d;
    end
  end
  assign bus.req_ready    = state_q == IDLE;
  assign bus.mem_req      = state_q == REQ;
  assign bus.mem_we       = req_q.we;
  assign bus.mem_addr     = req_q.addr & ~ADDR_WIDTH'(3);
  assign bus.mem_wstrb    = req_q.we ? req_q.wstrb : '0;
  assign bus.mem_wdata    = req_q.wdata;
  assign bus.data_ok      = data_ok_q;
  assign bus.cache_data_o = cache_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors with a scoreboard monitor checking every data_ok and the zero-data rule.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;
  logic [31:0] exp_q[$];
  localparam logic [31:0] GARBAGE = 32'h55AA_55AA;
  dmem_responder_if bus ();
  dmem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wstrb  = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = GARBAGE;
  endtask
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wstrb = strb;
    bus.req_wdata = wd;
  endtask
  // Monitor: every data_ok pops one expected word; any other cycle must show zero data.
  initial forever begin
    @(negedge clk);
    if (bus.data_ok) begin
      if (exp_q.size() == 0) check("unexpected_data_ok", 32'd1, 32'd0);
      else check("sb_data", bus.cache_data_o, exp_q.pop_front());
    end else check("zero_data", bus.cache_data_o, 32'd0);
  end
  initial begin
    idle_in();
    #2;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_data_ok", 32'(bus.data_ok), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    tick(); tick();
    rst = 1'b1;
    // Load 0x1000, ack immediately, rvalid next cycle.
    tick();
    issue(1'b0, 32'h1000, 4'hF, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    tick(); idle_in(); bus.mem_ack = 1'b1;
    check("t1_mem_req", 32'(bus.mem_req), 32'd1);
    check("t1_mem_addr", bus.mem_addr, 32'h1000);
    check("t1_mem_we", 32'(bus.mem_we), 32'd0);
    check("t1_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    tick(); idle_in(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    check("t1_no_ok_c2", 32'(bus.data_ok), 32'd0);
    tick(); idle_in();
    check("t1_ok_c3", 32'(bus.data_ok), 32'd1);
    check("t1_ready_c3", 32'(bus.req_ready), 32'd1);
    tick();
    check("t1_ok_c4", 32'(bus.data_ok), 32'd0);
    // Store 0x1002, ack delayed 4 cycles.
    issue(1'b1, 32'h1002, 4'b1100, 32'hABCD_0000);
    exp_q.push_back(32'h0);
    tick(); idle_in();
    for (int i = 0; i < 4; i++) begin
      check("t2_mem_req", 32'(bus.mem_req), 32'd1);
      check("t2_mem_addr", bus.mem_addr, 32'h1000);
      check("t2_mem_wstrb", 32'(bus.mem_wstrb), 32'hC);
      check("t2_mem_we", 32'(bus.mem_we), 32'd1);
      check("t2_mem_wdata", bus.mem_wdata, 32'hABCD_0000);
      tick();
    end
    bus.mem_ack = 1'b1;
    tick(); idle_in(); bus.mem_rvalid = 1'b1;
    check("t2_mem_req_off", 32'(bus.mem_req), 32'd0);
    tick(); idle_in();
    check("t2_ok", 32'(bus.data_ok), 32'd1);
    // Load flushed in WAIT two cycles before rvalid -> DRAIN.
    tick();
    issue(1'b0, 32'h2000, 4'hF, 32'h0);
    tick(); idle_in(); bus.mem_ack = 1'b1;
    tick(); idle_in(); bus.flush = 1'b1;
    tick(); idle_in();
    check("t3_ready_drain", 32'(bus.req_ready), 32'd0);
    tick(); idle_in(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    check("t3_ready_drain2", 32'(bus.req_ready), 32'd0);
    tick(); idle_in();
    check("t3_ready_idle", 32'(bus.req_ready), 32'd1);
    check("t3_no_ok", 32'(bus.data_ok), 32'd0);
    // Load flushed in REQ, ack three cycles later.
    issue(1'b0, 32'h3000, 4'hF, 32'h0);
    tick(); idle_in(); bus.flush = 1'b1;
    check("t4_mem_req0", 32'(bus.mem_req), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick(); idle_in();
      check("t4_mem_req_hold", 32'(bus.mem_req), 32'd1);
    end
    tick(); idle_in(); bus.mem_ack = 1'b1;
    check("t4_mem_req_ack", 32'(bus.mem_req), 32'd1);
    tick(); idle_in(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    check("t4_mem_req_off", 32'(bus.mem_req), 32'd0);
    tick(); idle_in();
    check("t4_no_ok", 32'(bus.data_ok), 32'd0);
    check("t4_ready", 32'(bus.req_ready), 32'd1);
    // req_valid with flush in IDLE is refused.
    issue(1'b0, 32'h4000, 4'hF, 32'h0); bus.flush = 1'b1;
    tick(); idle_in();
    check("t5_not_accepted", 32'(bus.mem_req), 32'd0);
    check("t5_still_idle", 32'(bus.req_ready), 32'd1);
    // Store flushed in WAIT still completes.
    issue(1'b1, 32'h3004, 4'b0011, 32'h0000_1234);
    exp_q.push_back(32'h0);
    tick(); idle_in(); bus.mem_ack = 1'b1;
    check("t5_store_addr", bus.mem_addr, 32'h3004);
    tick(); idle_in(); bus.flush = 1'b1;
    tick(); idle_in(); bus.flush = 1'b1; bus.mem_rvalid = 1'b1;
    check("t5_store_waiting", 32'(bus.req_ready), 32'd0);
    tick(); idle_in();
    check("t5_store_ok", 32'(bus.data_ok), 32'd1);
    // Asynchronous reset while in WAIT, then a normal load.
    tick();
    issue(1'b0, 32'h5000, 4'hF, 32'h0);
    tick(); idle_in(); bus.mem_ack = 1'b1;
    tick(); idle_in();
    check("t6_in_wait", 32'(bus.req_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_async_ready", 32'(bus.req_ready), 32'd1);
    check("t6_async_mem_req", 32'(bus.mem_req), 32'd0);
    check("t6_async_addr", bus.mem_addr, 32'd0);
    tick(); rst = 1'b1;
    tick();
    issue(1'b0, 32'h6008, 4'hF, 32'h0);
    exp_q.push_back(32'hCAFE_F00D);
    tick(); idle_in(); bus.mem_ack = 1'b1;
    check("t6_mem_addr", bus.mem_addr, 32'h6008);
    tick(); idle_in(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick(); idle_in();
    check("t6_ok", 32'(bus.data_ok), 32'd1);
    // Reset during a data_ok pulse clears the registered outputs at once.
    tick();
    issue(1'b0, 32'h7000, 4'hF, 32'h0);
    tick(); idle_in(); bus.mem_ack = 1'b1;
    tick(); idle_in(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0077;
    tick(); idle_in();
    check("t7_pulse", 32'(bus.data_ok), 32'd1);
    check("t7_pulse_data", bus.cache_data_o, 32'h77);
    #1 rst = 1'b0;
    #1;
    check("t7_rst_ok", 32'(bus.data_ok), 32'd0);
    check("t7_rst_data", bus.cache_data_o, 32'd0);
    tick(); rst = 1'b1;
    tick(); tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
